mcu_stripe_reader: RTL

MCU_STRIPE_READER -- requirements
Module: mcu_stripe_reader

---
 rtl/mcu_stripe_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mcu_stripe_reader.sv
// Streams one completed stripe (NUM_EBRS*MCUS_PER_EBR MCUs of 64 bytes) out of the
// back bank of an EBR double buffer, MCU by MCU, through a 2-entry registered skid buffer.
//
// state | meaning
// IDLE  | waiting for a frontbuffer_select toggle
// READ  | issuing EBR addresses, one per clock when the skid buffer has room
// DRAIN | all addresses issued, emptying the pipeline until the last pixel is accepted

module mcu_stripe_reader #(
   parameter int NUM_EBRS     = 5,
   parameter int MCUS_PER_EBR = 8
) (
   input  logic       clock,
   input  logic       nreset,
   input  logic       frontbuffer_select,
   output logic       read_bank,
   output logic [2:0] read_block_select,
   output logic [8:0] read_addr,
   input  logic [7:0] read_data,
   output logic [7:0] pix_data,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic       pix_first,
   output logic       pix_last_of_stripe,
   output logic       busy,
   output logic       overrun
);

   localparam int ROW_W = (MCUS_PER_EBR > 1) ? $clog2(MCUS_PER_EBR) : 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t           state, state_next;
   logic             fbs_q;
   logic [ROW_W-1:0] row_q;
   logic [5:0]       pix_q;
   logic             rd_valid_q, rd_first_q, rd_last_q;
   logic             skid_valid;
   logic [7:0]       skid_data;
   logic             skid_first, skid_last;

   logic             toggle, pop, room, issue, last_addr, last_mcu;
   logic [1:0]       occ_after;

   assign toggle    = frontbuffer_select ^ fbs_q;
   assign pop       = pix_valid & pix_ready;
   assign last_mcu  = (read_block_select == 3'(NUM_EBRS - 1)) &&
                      (row_q == ROW_W'(MCUS_PER_EBR - 1));
   assign last_addr = last_mcu && (pix_q == 6'd63);
   assign read_addr = 9'({row_q, pix_q});

   // Count what will still occupy the buffer after this edge, including the byte
   // returning now; a new address is only safe if its byte has a slot next clock.
   assign occ_after = 2'(pix_valid) + 2'(skid_valid) + 2'(rd_valid_q) - 2'(pop);
   assign room      = (occ_after <= 2'd1);
   assign issue     = (state == READ) && room;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (toggle) state_next = READ;
         READ:    if (issue && last_addr) state_next = DRAIN;
         DRAIN:   if (pop && pix_last_of_stripe) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         fbs_q              <= 1'b0;
         read_bank          <= 1'b0;
         read_block_select  <= 3'd0;
         row_q              <= '0;
         pix_q              <= 6'd0;
         busy               <= 1'b0;
         overrun            <= 1'b0;
         rd_valid_q         <= 1'b0;
         rd_first_q         <= 1'b0;
         rd_last_q          <= 1'b0;
         skid_valid         <= 1'b0;
         skid_data          <= 8'd0;
         skid_first         <= 1'b0;
         skid_last          <= 1'b0;
         pix_valid          <= 1'b0;
         pix_data           <= 8'd0;
         pix_first          <= 1'b0;
         pix_last_of_stripe <= 1'b0;
      end else begin
         fbs_q <= frontbuffer_select;

         if (state == IDLE && toggle) begin
            read_bank         <= ~frontbuffer_select;
            read_block_select <= 3'd0;
            row_q             <= '0;
            pix_q             <= 6'd0;
            busy              <= 1'b1;
         end else if (issue && !last_addr) begin
            pix_q <= pix_q + 6'd1;
            if (pix_q == 6'd63) begin
               if (read_block_select == 3'(NUM_EBRS - 1)) begin
                  read_block_select <= 3'd0;
                  row_q             <= row_q + ROW_W'(1);
               end else begin
                  read_block_select <= read_block_select + 3'd1;
               end
            end
         end

         if (toggle && state != IDLE) overrun <= 1'b1;
         if (state == DRAIN && pop && pix_last_of_stripe) busy <= 1'b0;

         rd_valid_q <= issue;
         rd_first_q <= (pix_q == 6'd0);
         rd_last_q  <= last_addr;

         if (!pix_valid || pop) begin
            if (skid_valid) begin
               pix_valid          <= 1'b1;
               pix_data           <= skid_data;
               pix_first          <= skid_first;
               pix_last_of_stripe <= skid_last;
               skid_valid         <= rd_valid_q;
               skid_data          <= read_data;
               skid_first         <= rd_first_q;
               skid_last          <= rd_last_q;
            end else if (rd_valid_q) begin
               pix_valid          <= 1'b1;
               pix_data           <= read_data;
               pix_first          <= rd_first_q;
               pix_last_of_stripe <= rd_last_q;
            end else begin
               pix_valid          <= 1'b0;
               pix_first          <= 1'b0;
               pix_last_of_stripe <= 1'b0;
            end
         end else if (rd_valid_q) begin
            skid_valid <= 1'b1;
            skid_data  <= read_data;
            skid_first <= rd_first_q;
            skid_last  <= rd_last_q;
         end
      end
   end

endmodule
